sdram_burst_engine: RTL and testbench

- Responder side of the FIFO request/ack handshake.
- Accepts sdram_wr_req / sdram_rd_req from the FIFO controller and returns sdram_wr_ack / sdram_rd_ack, timed so that words move between the FIFOs and the SDRAM data bus.
- Sequences ACTIVE, WRITE/READ with auto-precharge and AUTO REFRESH commands.
- Owns the write and read address counters, and asserts syswr_done when the write region is full.

---
 rtl/sdram_pkg.sv | 39 +++
 rtl/sdram_burst_engine_if.sv | 38 +++
 rtl/sdram_ref_timer.sv | 43 ++++
 rtl/sdram_burst_engine.sv | 185 ++++++++++++++++++
 tb/tb_sdram_burst_engine.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM burst engine.
//   - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
//   - engine FSM state type
//   - word-address field layout {bank, row, col}
//   - helper building the READ/WRITE address word (column + auto-precharge bit)
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_NOP   = 4'b0111,
    CMD_ACT   = 4'b0011,
    CMD_READ  = 4'b0101,
    CMD_WRITE = 4'b0100,
    CMD_PRE   = 4'b0010,
    CMD_AREF  = 4'b0001
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REF,
    ST_REF_WAIT,
    ST_ACT,
    ST_RCD_WAIT,
    ST_WR_BURST,
    ST_RD_BURST,
    ST_PRE_WAIT
  } state_e;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 22;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned ROW_W  = 12;
  localparam int unsigned COL_W  = 8;

  // Column in A[7:0], A10 set so the burst closes its row by auto-precharge.
  function automatic logic [ROW_W-1:0] rw_addr(input logic [COL_W-1:0] col);
    return {1'b0, 1'b1, 2'b00, col};
  endfunction

endpackage

// File: rtl/sdram_burst_engine_if.sv
// sdram_burst_engine_if: FIFO handshake and SDRAM bus signals of the burst engine.
//   slave  modport: the engine (responds to FIFO requests, drives the SDRAM bus)
//   master modport: the FIFO controller / pad side
//   FIFO side : init_done, sdram_wr_req/ack, sys_data_in, sdram_rd_req/ack,
//               sys_data_out, syswr_done, busy
//   SDRAM side: sdram_cmd, sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, sdram_dq_in
interface sdram_burst_engine_if;
  import sdram_pkg::*;

  logic              init_done;
  logic              sdram_wr_req;
  logic              sdram_wr_ack;
  logic [DATA_W-1:0] sys_data_in;
  logic              sdram_rd_req;
  logic              sdram_rd_ack;
  logic [DATA_W-1:0] sys_data_out;
  logic              syswr_done;
  logic [3:0]        sdram_cmd;
  logic [BANK_W-1:0] sdram_ba;
  logic [ROW_W-1:0]  sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;
  logic [DATA_W-1:0] sdram_dq_in;
  logic              busy;

  modport slave (
    input  init_done, sdram_wr_req, sys_data_in, sdram_rd_req, sdram_dq_in,
    output sdram_wr_ack, sdram_rd_ack, sys_data_out, syswr_done, sdram_cmd,
           sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, busy
  );

  modport master (
    output init_done, sdram_wr_req, sys_data_in, sdram_rd_req, sdram_dq_in,
    input  sdram_wr_ack, sdram_rd_ack, sys_data_out, syswr_done, sdram_cmd,
           sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, busy
  );

endinterface

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer: free-running refresh interval counter.
//   clk_100m      : system clock
//   rst_n         : synchronous reset, active-low
//   ref_clr_i     : AREF being issued this cycle
//   ref_pending_o : a refresh is owed; only one can be outstanding
module sdram_ref_timer #(
  parameter int unsigned REF_PERIOD = 1560
) (
  input  logic clk_100m,
  input  logic rst_n,
  input  logic ref_clr_i,
  output logic ref_pending_o
);

  localparam int unsigned CW = $clog2(REF_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(REF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          expire;

  always_comb begin
    expire = (cnt_q == LAST);
    cnt_d  = expire ? '0 : cnt_q + 1'b1;
    pend_d = pend_q;
    if (ref_clr_i) pend_d = 1'b0;
    // A fresh expiry owes a new refresh even if one is being issued now.
    if (expire)    pend_d = 1'b1;
  end

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign ref_pending_o = pend_q;

endmodule

// File: rtl/sdram_burst_engine.sv
// sdram_burst_engine: responder for the FIFO burst handshake; sequences
// ACTIVE -> WRITE/READ (auto-precharge) and AUTO REFRESH on the SDRAM bus.
//   clk_100m : system clock
//   rst_n    : synchronous reset, active-low
//   bus      : sdram_burst_engine_if.slave (FIFO handshake + SDRAM bus)
// Owns the write/read word-address counters; syswr_done is sticky once the
// write region is full. T_RCD and T_RFC are assumed to be at least 2.
module sdram_burst_engine
  import sdram_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned CAS_LAT    = 2,
  parameter int unsigned T_RCD      = 2,
  parameter int unsigned T_RP       = 2,
  parameter int unsigned T_WR       = 2,
  parameter int unsigned T_RFC      = 7,
  parameter int unsigned REF_PERIOD = 1560,
  parameter int unsigned WR_LIMIT   = 1024
) (
  input  logic                clk_100m,
  input  logic                rst_n,
  sdram_burst_engine_if.slave bus
);

  localparam int unsigned CNT_W =
    $clog2(CAS_LAT + BURST_LEN + T_WR + T_RP + T_RFC + T_RCD + 2);

  localparam logic [CNT_W-1:0] RCD_LAST    = CNT_W'(T_RCD - 2);
  localparam logic [CNT_W-1:0] RFC_LAST    = CNT_W'(T_RFC - 2);
  localparam logic [CNT_W-1:0] WR_LAST     = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] RD_LAST     = CNT_W'(CAS_LAT + BURST_LEN);
  localparam logic [CNT_W-1:0] RD_ACK_1ST  = CNT_W'(CAS_LAT + 1);
  localparam logic [CNT_W-1:0] PRE_WR_LAST = CNT_W'(T_WR + T_RP - 1);
  localparam logic [CNT_W-1:0] PRE_RD_LAST = CNT_W'(T_RP - 1);
  localparam logic [ADDR_W-1:0] BL_A  = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] LIM_A = ADDR_W'(WR_LIMIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q;

  logic              ref_pending;
  logic [ADDR_W-1:0] addr_sel;
  sdram_cmd_e        cmd;
  logic [BANK_W-1:0] ba;
  logic [ROW_W-1:0]  addr;
  logic              wr_ack, rd_ack, dq_oe;

  sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
    .clk_100m      (clk_100m),
    .rst_n         (rst_n),
    .ref_clr_i     (state_q == ST_REF),
    .ref_pending_o (ref_pending)
  );

  always_comb begin
    // Counters only move at burst end, so they address the whole transaction.
    addr_sel  = is_wr_q ? wr_addr_q : rd_addr_q;
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    is_wr_d   = is_wr_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    done_d    = done_q;
    cmd       = CMD_NOP;
    ba        = '0;
    addr      = '0;
    wr_ack    = 1'b0;
    rd_ack    = 1'b0;
    dq_oe     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.init_done) begin
          if (ref_pending) begin
            state_d = ST_REF;
          end else if (bus.sdram_wr_req && !done_q) begin
            state_d = ST_ACT;
            is_wr_d = 1'b1;
          end else if (bus.sdram_rd_req) begin
            state_d = ST_ACT;
            is_wr_d = 1'b0;
          end
        end
      end
      ST_REF: begin
        cmd     = CMD_AREF;
        cnt_d   = '0;
        state_d = ST_REF_WAIT;
      end
      ST_REF_WAIT: begin
        if (cnt_q == RFC_LAST) state_d = ST_IDLE;
      end
      ST_ACT: begin
        cmd     = CMD_ACT;
        ba      = addr_sel[ADDR_W-1 -: BANK_W];
        addr    = addr_sel[COL_W +: ROW_W];
        cnt_d   = '0;
        state_d = ST_RCD_WAIT;
      end
      ST_RCD_WAIT: begin
        if (cnt_q == RCD_LAST) begin
          // FIFO q lags its read strobe by one cycle, so the first ack leads WRITE.
          wr_ack  = is_wr_q;
          cnt_d   = '0;
          state_d = is_wr_q ? ST_WR_BURST : ST_RD_BURST;
        end
      end
      ST_WR_BURST: begin
        dq_oe  = 1'b1;
        wr_ack = (cnt_q != WR_LAST);
        if (cnt_q == '0) begin
          cmd  = CMD_WRITE;
          ba   = addr_sel[ADDR_W-1 -: BANK_W];
          addr = rw_addr(addr_sel[COL_W-1:0]);
        end
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          state_d = ST_PRE_WAIT;
          if (wr_addr_q + BL_A >= LIM_A) begin
            wr_addr_d = LIM_A;
            done_d    = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + BL_A;
          end
        end
      end
      ST_RD_BURST: begin
        // Read data lands CAS_LAT after READ and is registered once more.
        rd_ack = (cnt_q >= RD_ACK_1ST);
        if (cnt_q == '0) begin
          cmd  = CMD_READ;
          ba   = addr_sel[ADDR_W-1 -: BANK_W];
          addr = rw_addr(addr_sel[COL_W-1:0]);
        end
        if (cnt_q == RD_LAST) begin
          cnt_d     = '0;
          state_d   = ST_PRE_WAIT;
          rd_addr_d = (rd_addr_q + BL_A >= LIM_A) ? '0 : rd_addr_q + BL_A;
        end
      end
      ST_PRE_WAIT: begin
        if (cnt_q == (is_wr_q ? PRE_WR_LAST : PRE_RD_LAST)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      done_q    <= done_d;
      rdata_q   <= bus.sdram_dq_in;
    end
  end

  assign bus.sdram_cmd    = cmd;
  assign bus.sdram_ba     = ba;
  assign bus.sdram_addr   = addr;
  assign bus.sdram_wr_ack = wr_ack;
  assign bus.sdram_rd_ack = rd_ack;
  assign bus.sdram_dq_oe  = dq_oe;
  assign bus.sdram_dq_out = dq_oe ? bus.sys_data_in : '0;
  assign bus.sys_data_out = rdata_q;
  assign bus.syswr_done   = done_q;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_burst_engine.sv
// tb_sdram_burst_engine: directed checks of the SDRAM burst engine
// (CAS_LAT=3, otherwise default timing).
module tb_sdram_burst_engine;

  localparam logic [3:0] NOP   = 4'b0111;
  localparam logic [3:0] ACT   = 4'b0011;
  localparam logic [3:0] READ  = 4'b0101;
  localparam logic [3:0] WRITE = 4'b0100;
  localparam logic [3:0] AREF  = 4'b0001;

  logic        clk_100m = 1'b0;
  logic        rst_n;
  logic [15:0] fifo_idx;
  int unsigned nchk = 0;
  int unsigned nfail = 0;
  int unsigned tk = 0;

  sdram_burst_engine_if bus();

  sdram_burst_engine #(
    .BURST_LEN(8), .CAS_LAT(3), .T_RCD(2), .T_RP(2), .T_WR(2),
    .T_RFC(7), .REF_PERIOD(1560), .WR_LIMIT(1024)
  ) dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_100m = ~clk_100m;

  // Write FIFO: q advances one word after each read strobe.
  always @(posedge clk_100m) begin
    if (!rst_n) fifo_idx <= '0;
    else if (bus.sdram_wr_ack) fifo_idx <= fifo_idx + 16'd1;
  end
  assign bus.sys_data_in = 16'hC000 + fifo_idx;

  // tk = clock edges since the last reset edge (mirrors the refresh timer).
  task automatic tick();
    @(posedge clk_100m);
    if (rst_n) tk++;
    else tk = 0;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cmd(input logic [3:0] c, input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (bus.sdram_cmd !== c && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.sdram_cmd), 32'(c));
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk("idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int unsigned bad;
    int unsigned acks;
    int unsigned n;

    rst_n = 1'b0;
    bus.init_done = 1'b0;
    bus.sdram_wr_req = 1'b1;
    bus.sdram_rd_req = 1'b0;
    bus.sdram_dq_in = '0;
    repeat (3) tick();
    chk("rst_cmd", 32'(bus.sdram_cmd), 32'(NOP));
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr_ack", 32'(bus.sdram_wr_ack), 32'd0);
    chk("rst_rd_ack", 32'(bus.sdram_rd_ack), 32'd0);
    chk("rst_dq_oe", 32'(bus.sdram_dq_oe), 32'd0);
    chk("rst_done", 32'(bus.syswr_done), 32'd0);
    chk("rst_ba", 32'(bus.sdram_ba), 32'd0);
    chk("rst_addr", 32'(bus.sdram_addr), 32'd0);
    chk("rst_sdo", 32'(bus.sys_data_out), 32'd0);
    chk("rst_dq_out", 32'(bus.sdram_dq_out), 32'd0);
    rst_n = 1'b1;

    // init_done low: requests must be ignored.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.sdram_cmd !== NOP || bus.sdram_wr_ack !== 1'b0 ||
          bus.sdram_rd_ack !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("no_init_idle", bad, 32'd0);

    // First write burst at address 0.
    bus.init_done = 1'b1;
    tick();
    chk("w1_act", 32'(bus.sdram_cmd), 32'(ACT));
    chk("w1_act_ba", 32'(bus.sdram_ba), 32'd0);
    chk("w1_act_row", 32'(bus.sdram_addr), 32'd0);
    chk("w1_busy", 32'(bus.busy), 32'd1);
    bus.sdram_wr_req = 1'b0;
    tick();
    chk("w1_rcd_cmd", 32'(bus.sdram_cmd), 32'(NOP));
    chk("w1_rcd_ack", 32'(bus.sdram_wr_ack), 32'd1);
    chk("w1_rcd_oe", 32'(bus.sdram_dq_oe), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("w1_cmd", 32'(bus.sdram_cmd), (k == 0) ? 32'(WRITE) : 32'(NOP));
      if (k == 0) chk("w1_wr_addr", 32'(bus.sdram_addr), 32'h400);
      chk("w1_oe", 32'(bus.sdram_dq_oe), 32'd1);
      chk("w1_dq", 32'(bus.sdram_dq_out), 32'hC001 + 32'(k));
      chk("w1_ack", 32'(bus.sdram_wr_ack), (k < 7) ? 32'd1 : 32'd0);
    end
    tick();
    chk("w1_end_ack", 32'(bus.sdram_wr_ack), 32'd0);
    chk("w1_end_oe", 32'(bus.sdram_dq_oe), 32'd0);
    repeat (3) tick();
    chk("w1_pre_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("w1_pre_done", 32'(bus.busy), 32'd0);

    // Fill the write region: bursts 1..127.
    bus.sdram_wr_req = 1'b1;
    for (int b = 1; b < 128; b++) begin
      wait_cmd(ACT, 40, "wn_act");
      chk("wn_row", 32'(bus.sdram_addr), 32'(b >> 5));
      tick();
      tick();
      chk("wn_write", 32'(bus.sdram_cmd), 32'(WRITE));
      chk("wn_col", 32'(bus.sdram_addr), 32'h400 | 32'((b * 8) & 255));
    end
    repeat (7) tick();
    chk("full_before_end", 32'(bus.syswr_done), 32'd0);
    tick();
    chk("full_at_end", 32'(bus.syswr_done), 32'd1);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.sdram_cmd === ACT) bad++;
    end
    chk("full_no_act", bad, 32'd0);
    chk("full_sticky", 32'(bus.syswr_done), 32'd1);
    bus.sdram_wr_req = 1'b0;

    // Read burst at rd_addr 0, CAS latency 3.
    wait_idle(40);
    bus.sdram_rd_req = 1'b1;
    wait_cmd(ACT, 40, "r1_act");
    bus.sdram_rd_req = 1'b0;
    chk("r1_act_row", 32'(bus.sdram_addr), 32'd0);
    tick();
    tick();
    chk("r1_read", 32'(bus.sdram_cmd), 32'(READ));
    chk("r1_read_addr", 32'(bus.sdram_addr), 32'h400);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("r1_ack", 32'(bus.sdram_rd_ack), (k >= 4 && k <= 11) ? 32'd1 : 32'd0);
      if (k >= 4 && k <= 11) chk("r1_data", 32'(bus.sys_data_out), 32'hA000 + 32'(k - 4));
      bus.sdram_dq_in = (k >= 3 && k <= 10) ? 16'hA000 + 16'(k - 3) : 16'h0000;
    end

    // Reset in the middle of the second read burst.
    wait_idle(40);
    bus.sdram_rd_req = 1'b1;
    wait_cmd(ACT, 40, "r2_act");
    bus.sdram_rd_req = 1'b0;
    tick();
    tick();
    chk("r2_read", 32'(bus.sdram_cmd), 32'(READ));
    chk("r2_read_addr", 32'(bus.sdram_addr), 32'h408);
    bus.sdram_dq_in = 16'h5A5A;
    repeat (5) tick();
    chk("r2_ack_live", 32'(bus.sdram_rd_ack), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mrst_cmd", 32'(bus.sdram_cmd), 32'(NOP));
    chk("mrst_rd_ack", 32'(bus.sdram_rd_ack), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_sdo", 32'(bus.sys_data_out), 32'd0);
    chk("mrst_done", 32'(bus.syswr_done), 32'd0);
    rst_n = 1'b1;
    bus.sdram_dq_in = '0;

    // Clean write after reset (wr_addr back at 0).
    bus.sdram_wr_req = 1'b1;
    wait_cmd(ACT, 10, "w2_act");
    bus.sdram_wr_req = 1'b0;
    chk("w2_act_row", 32'(bus.sdram_addr), 32'd0);
    tick();
    chk("w2_rcd_ack", 32'(bus.sdram_wr_ack), 32'd1);
    tick();
    chk("w2_write", 32'(bus.sdram_cmd), 32'(WRITE));
    chk("w2_write_addr", 32'(bus.sdram_addr), 32'h400);
    acks = 1;
    for (int k = 0; k < 9; k++) begin
      if (bus.sdram_wr_ack === 1'b1) acks++;
      tick();
    end
    chk("w2_acks", acks, 32'd8);
    wait_idle(20);

    // rd_addr back at 0 after reset.
    bus.sdram_rd_req = 1'b1;
    wait_cmd(ACT, 10, "r3_act");
    bus.sdram_rd_req = 1'b0;
    tick();
    tick();
    chk("r3_read", 32'(bus.sdram_cmd), 32'(READ));
    chk("r3_read_addr", 32'(bus.sdram_addr), 32'h400);
    wait_idle(40);

    // Refresh expires (edge 1560) inside a write burst starting at edge 1555.
    while (tk < 1552) tick();
    bus.sdram_wr_req = 1'b1;
    tick();
    chk("ref_w_act", 32'(bus.sdram_cmd), 32'(ACT));
    tick();
    tick();
    chk("ref_w_write", 32'(bus.sdram_cmd), 32'(WRITE));
    n = 0;
    acks = 0;
    do begin
      if (bus.sdram_wr_ack === 1'b1) acks++;
      tick();
      n++;
    end while (bus.sdram_cmd === NOP && n < 40);
    chk("ref_next_cmd", 32'(bus.sdram_cmd), 32'(AREF));
    chk("ref_aref_delay", n, 32'd13);
    chk("ref_burst_acks", acks, 32'd7);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.sdram_cmd !== ACT && n < 40);
    chk("ref_then_act", 32'(bus.sdram_cmd), 32'(ACT));
    chk("ref_rfc_gap", n, 32'd8);
    bus.sdram_wr_req = 1'b0;
    wait_idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
